multi_timer: RTL and testbench

Multi-channel countdown timer: a parametrised successor to the single-channel Timer with reload, periodic mode, per-channel programmable prescaler and a shared, maskable interrupt line with write-1-to-clear pending bits. It sits on the CPU's memory-mapped peripheral bus beside the other I/O blocks. It drives one interrupt input of the interrupt controller.

---
 rtl/multi_timer.sv | 136 +++++++++++++
 tb/tb_multi_timer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent countdown timers with reload, periodic
// mode, a per-channel power-of-two prescaler and a shared maskable interrupt.
// Register map per channel {channel, reg}: 0 LOAD, 1 COUNT (read-only),
// 2 CTRL {ps[6:4], irq_en[2], periodic[1], en[0]}, 3 STATUS (global, W1C).
module multi_timer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32,
    localparam int AW      = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       addr,
    input  logic                write,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    data_out,
    output logic [CHANNELS-1:0] irq_pending,
    output logic                timer_interrupt
);

    localparam logic [AW-1:0] CH_LIMIT = AW'(CHANNELS);

    logic [WIDTH-1:0]    load_q  [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [2:0]          ps_q    [CHANNELS];
    logic [6:0]          presc_q [CHANNELS];
    logic [CHANNELS-1:0] en_q;
    logic [CHANNELS-1:0] periodic_q;
    logic [CHANNELS-1:0] irq_en_q;
    logic [CHANNELS-1:0] pending_q;
    logic                irq_q;

    logic [AW-1:0]       ch_idx;
    logic [1:0]          reg_sel;
    logic                ch_valid;
    logic [CHANNELS-1:0] clear_mask;
    logic [CHANNELS-1:0] load_wr;
    logic [CHANNELS-1:0] ctrl_wr;
    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] irq_en_next;
    logic [CHANNELS-1:0] pending_next;

    assign ch_idx   = addr >> 2;
    assign reg_sel  = addr[1:0];
    assign ch_valid = (ch_idx < CH_LIMIT);

    assign irq_pending     = pending_q;
    assign timer_interrupt = irq_q;

    // Decode bus writes and work out which channels tick or expire this cycle.
    always_comb begin
        load_wr      = '0;
        ctrl_wr      = '0;
        active       = '0;
        tick         = '0;
        expire       = '0;
        irq_en_next  = irq_en_q;
        clear_mask   = (write && reg_sel == 2'd3) ? data_in[CHANNELS-1:0] : '0;
        for (int c = 0; c < CHANNELS; c++) begin
            load_wr[c]     = write && ch_valid && (ch_idx == AW'(c)) && (reg_sel == 2'd0);
            ctrl_wr[c]     = write && ch_valid && (ch_idx == AW'(c)) && (reg_sel == 2'd2);
            active[c]      = en_q[c] && (count_q[c] != '0);
            tick[c]        = active[c] && (presc_q[c] == ((7'd1 << ps_q[c]) - 7'd1));
            expire[c]      = tick[c] && (count_q[c] == WIDTH'(1));
            irq_en_next[c] = ctrl_wr[c] ? data_in[2] : irq_en_q[c];
        end
        pending_next = (pending_q & ~clear_mask) | expire;
    end

    // Channel state: a LOAD write overrides the count; a CTRL write only restarts the prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                load_q[c]  <= '0;
                count_q[c] <= '0;
                ps_q[c]    <= '0;
                presc_q[c] <= '0;
            end
            en_q       <= '0;
            periodic_q <= '0;
            irq_en_q   <= '0;
            pending_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (load_wr[c]) begin
                    load_q[c]  <= data_in;
                    count_q[c] <= data_in;
                    presc_q[c] <= '0;
                end else begin
                    if (tick[c]) begin
                        if (expire[c]) begin
                            count_q[c] <= periodic_q[c] ? load_q[c] : '0;
                        end else begin
                            count_q[c] <= count_q[c] - WIDTH'(1);
                        end
                    end
                    if (ctrl_wr[c]) begin
                        presc_q[c] <= '0;
                    end else if (active[c]) begin
                        presc_q[c] <= tick[c] ? 7'd0 : presc_q[c] + 7'd1;
                    end
                end
                if (ctrl_wr[c]) begin
                    en_q[c]       <= data_in[0];
                    periodic_q[c] <= data_in[1];
                    irq_en_q[c]   <= data_in[2];
                    ps_q[c]       <= data_in[6:4];
                end
            end
            pending_q <= pending_next;
            irq_q     <= |(pending_next & irq_en_next);
        end
    end

    // Zero-latency read mux; unimplemented channels read 0 except the STATUS alias.
    always_comb begin
        data_out = '0;
        if (reg_sel == 2'd3) begin
            data_out = WIDTH'(pending_q);
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_valid && (ch_idx == AW'(c))) begin
                    case (reg_sel)
                        2'd0:    data_out = load_q[c];
                        2'd1:    data_out = count_q[c];
                        2'd2:    data_out = WIDTH'({ps_q[c], 1'b0, irq_en_q[c], periodic_q[c], en_q[c]});
                        default: data_out = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: randomized scoreboard bench for multi_timer. Stimulus
// schedules each channel's expiry edge (LOAD * 2^ps after the LOAD edge, plus
// any frozen cycles) into a per-channel queue; a monitor pops an entry each
// time a pending bit rises and compares the edge number.
module tb_multi_timer;

    localparam int NCH = 3;
    localparam int W   = 32;
    localparam int AW  = $clog2(NCH) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic [NCH-1:0] irq_pending;
    logic          timer_interrupt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q [NCH][$];
    logic [NCH-1:0] model_irq_en = '0;
    logic [NCH-1:0] prev_pend = '0;

    multi_timer #(.CHANNELS(NCH), .WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .write           (write),
        .data_in         (data_in),
        .data_out        (data_out),
        .irq_pending     (irq_pending),
        .timer_interrupt (timer_interrupt)
    );

    // Free-running clock and a count of rising edges used as the time base.
    always #5 clk = ~clk;

    // Edge counter: after the Nth rising edge, cyc reads N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] ra(input int ch, input int r);
        return AW'(ch * 4 + r);
    endfunction

    function automatic bit any_expected();
        for (int c = 0; c < NCH; c++) if (exp_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // All bus tasks enter and leave on a falling edge.
    task automatic bus_write_at(input int ch, input int r, input logic [W-1:0] d, output int edge_no);
        addr = ra(ch, r);
        data_in = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        edge_no = cyc;
    endtask

    task automatic bus_write(input int ch, input int r, input logic [W-1:0] d);
        addr = ra(ch, r);
        data_in = d;
        write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [W-1:0] d);
        addr = ra(ch, r);
        write = 1'b0;
        #1;
        d = data_out;
        @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (any_expected() && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (any_expected()) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL drain_timeout: expiries still outstanding after %0d cycles", budget);
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
        end
    endtask

    // Monitor: match each rising pending bit against the scheduled expiry edge
    // and check the interrupt is the OR of the masked pending bits.
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            prev_pend = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (irq_pending[c] && !prev_pend[c]) begin
                    if (exp_q[c].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL unexpected_expiry ch%0d: pending rose at edge %0d, none scheduled", c, cyc);
                    end else begin
                        int e;
                        e = exp_q[c].pop_front();
                        check_output($sformatf("expiry_edge_ch%0d", c), W'(cyc), W'(e));
                    end
                end else if (exp_q[c].size() != 0 && exp_q[c][0] < cyc) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL missed_expiry ch%0d: pending low at edge %0d, expected by %0d", c, cyc, exp_q[c][0]);
                    void'(exp_q[c].pop_front());
                end
            end
            prev_pend = irq_pending;
            check_output("irq_or", W'(timer_interrupt), W'(|(irq_pending & model_irq_en)));
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int e;
        int e0;
        int e1;
        int e2;
        int f;
        int n;
        int loads [NCH];
        int pss [NCH];
        logic [W-1:0] d;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state: every register, including the unimplemented channel, reads 0.
        for (int ch = 0; ch < 4; ch++) begin
            for (int r = 0; r < 4; r++) begin
                bus_read(ch, r, d);
                check_output($sformatf("reset_reg_ch%0d_r%0d", ch, r), d, '0);
            end
        end
        check_output("reset_pending", W'(irq_pending), '0);
        check_output("reset_irq", W'(timer_interrupt), '0);

        // Asynchronous reset mid-count aborts the count with no interrupt.
        bus_write(0, 2, 32'h5);
        model_irq_en[0] = 1'b1;
        bus_write_at(0, 0, 32'd1000, e);
        exp_q[0].push_back(e + 1000);
        repeat (20) @(negedge clk);
        addr = ra(0, 1);
        #1;
        check_output("count_before_reset", data_out, W'(1000 - (cyc - e)));
        #2;
        rst = 1'b0;
        exp_q[0].delete();
        model_irq_en = '0;
        #1;
        check_output("reset_async_count", data_out, '0);
        check_output("reset_async_pending", W'(irq_pending), '0);
        check_output("reset_async_irq", W'(timer_interrupt), '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (100) @(negedge clk);
        check_output("post_reset_irq", W'(timer_interrupt), '0);

        // One-shot expiry for every prescaler setting.
        for (int ps = 0; ps < 8; ps++) begin
            bus_write(0, 2, W'(5 | (ps << 4)));
            model_irq_en[0] = 1'b1;
            n = $urandom_range(1, 2000 >> ps);
            bus_write_at(0, 0, W'(n), e);
            exp_q[0].push_back(e + (n << ps));
            wait_drain((n << ps) + 20);
            bus_read(0, 1, d);
            check_output($sformatf("oneshot_count_zero_ps%0d", ps), d, '0);
            bus_write(0, 3, 32'h1);
            check_output($sformatf("oneshot_w1c_ps%0d", ps), W'(irq_pending), '0);
        end

        // LOAD of 0 never fires.
        bus_write(0, 2, 32'h5);
        bus_write(0, 0, 32'd0);
        repeat (50) @(negedge clk);
        bus_read(0, 1, d);
        check_output("load0_count", d, '0);
        check_output("load0_pending", W'(irq_pending), '0);

        // Periodic: LOAD=5, ps=1 re-expires every 10 edges; W1C clears, set beats clear.
        bus_write(1, 2, 32'h17);
        model_irq_en[1] = 1'b1;
        bus_write_at(1, 0, 32'd5, e0);
        exp_q[1].push_back(e0 + 10);
        exp_q[1].push_back(e0 + 20);
        wait_until(e0 + 10);
        bus_write(1, 3, 32'h2);
        check_output("periodic_w1c_irq", W'(timer_interrupt), '0);
        bus_read(1, 3, d);
        check_output("periodic_w1c_status", d, '0);
        wait_drain(30);
        wait_until(e0 + 29);
        bus_write(1, 3, 32'h2);
        bus_read(1, 3, d);
        check_output("periodic_set_beats_clear", d, 32'h2);
        check_output("periodic_irq_held", W'(timer_interrupt), 32'h1);
        bus_write(1, 2, 32'h0);
        model_irq_en[1] = 1'b0;
        bus_write(1, 0, 32'd0);
        bus_write(1, 3, 32'h2);
        check_output("periodic_cleanup", W'(irq_pending), '0);

        // All channels concurrently with distinct prescalers; channel 2 masked.
        for (int c = 0; c < NCH; c++) begin
            pss[c] = c * 2 + $urandom_range(0, 1);
            loads[c] = $urandom_range(10, 150);
            bus_write(c, 2, W'(1 | ((c != 2) ? 4 : 0) | (pss[c] << 4)));
            model_irq_en[c] = (c != 2);
        end
        for (int c = 0; c < NCH; c++) begin
            bus_write_at(c, 0, W'(loads[c]), e);
            exp_q[c].push_back(e + (loads[c] << pss[c]));
        end
        wait_drain(6000);
        bus_read(0, 3, d);
        check_output("concurrent_all_pending", d, 32'h7);
        check_output("concurrent_irq", W'(timer_interrupt), 32'h1);
        bus_write(0, 3, 32'h3);
        check_output("masked_pending_only", W'(irq_pending), 32'h4);
        check_output("masked_no_irq", W'(timer_interrupt), '0);
        bus_write(0, 3, 32'h4);

        // Two channels expiring on the same edge.
        bus_write(0, 2, 32'h5);
        bus_write(1, 2, 32'h5);
        model_irq_en = 3'b011;
        bus_write_at(0, 0, 32'd40, e);
        exp_q[0].push_back(e + 40);
        bus_write_at(1, 0, 32'd39, e1);
        exp_q[1].push_back(e1 + 39);
        wait_drain(100);
        bus_read(0, 3, d);
        check_output("same_cycle_pending", d, 32'h3);
        bus_write(0, 3, 32'h3);
        bus_write(1, 2, 32'h0);
        model_irq_en[1] = 1'b0;

        // CTRL readback keeps only defined fields.
        bus_write(0, 2, 32'hA5A5_A505);
        model_irq_en[0] = 1'b1;
        bus_read(0, 2, d);
        check_output("ctrl_readback", d, 32'h05);

        // en=0 for 7 cycles mid-count shifts the expiry by exactly 7 edges.
        bus_write_at(0, 0, 32'd50, e0);
        exp_q[0].push_back(e0 + 50 + 7);
        wait_until(e0 + 19);
        bus_write_at(0, 2, 32'h4, f);
        bus_read(0, 1, d);
        check_output("freeze_count", d, W'(50 - (f - e0)));
        repeat (5) @(negedge clk);
        bus_write(0, 2, 32'h5);
        wait_drain(100);
        bus_write(0, 3, 32'h1);

        // LOAD rewrite mid-count restarts from the new value.
        bus_write_at(0, 0, 32'd60, e0);
        exp_q[0].push_back(e0 + 60);
        wait_until(e0 + 29);
        bus_write_at(0, 0, 32'd25, e1);
        exp_q[0].delete();
        exp_q[0].push_back(e1 + 25);
        bus_read(0, 1, d);
        check_output("reload_count", d, 32'd25);
        wait_drain(100);
        bus_write(0, 3, 32'h1);

        // Writes to COUNT are ignored.
        bus_write_at(0, 0, 32'd80, e0);
        exp_q[0].push_back(e0 + 80);
        repeat (9) @(negedge clk);
        bus_write_at(0, 1, 32'd3, e2);
        bus_read(0, 1, d);
        check_output("count_write_ignored", d, W'(80 - (e2 - e0)));
        bus_read(0, 0, d);
        check_output("count_write_load", d, 32'd80);
        wait_drain(150);

        // Unimplemented channel 3: reads 0, writes ignored, STATUS alias works.
        bus_write(3, 0, 32'd7);
        bus_write(3, 2, 32'h5);
        for (int r = 0; r < 3; r++) begin
            bus_read(3, r, d);
            check_output($sformatf("unimpl_read_r%0d", r), d, '0);
        end
        bus_read(3, 3, d);
        check_output("unimpl_status_alias", d, 32'h1);
        bus_read(0, 0, d);
        check_output("unimpl_ch0_load", d, 32'd80);
        bus_read(0, 2, d);
        check_output("unimpl_ch0_ctrl", d, 32'h05);
        bus_write(3, 3, 32'h1);
        bus_read(0, 3, d);
        check_output("unimpl_alias_w1c", d, '0);
        repeat (50) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
